uart_tx_phy: RTL and testbench

//   Serial transmit engine of the UART. Pops bytes from the TX FIFO and drives 8N1/8N2 frames
//   on the txd line, LSB first. Controlled by txen, nstop and div from the UART register bank.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_phy.sv | 145 ++++++++++++++
 tb/tb_uart_tx_phy.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_t    : transmit FSM state encoding
//   UartDataBits  : payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    Idle  = 3'd0,
    Fetch = 3'd1,
    Start = 3'd2,
    Data  = 3'd3,
    Stop  = 3'd4
  } tx_state_t;

  localparam integer UartDataBits = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter.
//   Counts 0..i_div while enabled and flags the last cycle of each bit.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-high reset
//   i_clr     in   synchronous clear, restarts the bit period at zero
//   i_en      in   count enable (frame in progress)
//   i_div     in   latched divisor; bit period = i_div+1 cycles
//   o_bit_end out  high on the last cycle of the current bit
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_bit_end
);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign o_bit_end = i_en & (r_cnt == i_div);

  // Bit-period counter; wraps to zero at the end of every bit and rests at zero when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= {DIV_WIDTH{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {DIV_WIDTH{1'b0}};
    end else if (i_en) begin
      if (o_bit_end) begin
        r_cnt <= {DIV_WIDTH{1'b0}};
      end else begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end
    end else begin
      r_cnt <= {DIV_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/uart_tx_phy.sv
// uart_tx_phy: UART serial transmit engine (8N1 / 8N2, LSB first).
//   Pops bytes from the TX FIFO and serialises them onto txd.
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous active-high reset
//   txen          in   transmit enable
//   nstop         in   0: one stop bit, 1: two stop bits
//   div           in   baud divisor; bit period = div+1 cycles
//   fifo_rd_data  in   FIFO head, valid the cycle after fifo_rd_en
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_en    out  pop request, one cycle per byte
//   txd           out  serial line, idle high (registered)
//   busy          out  high whenever the engine is not idle
module uart_tx_phy #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 txen,
  input  logic                 nstop,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           fifo_rd_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy
);

  import uart_pkg::*;

  localparam logic [2:0] LastBit = 3'(UartDataBits - 1);

  tx_state_t            r_state;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic                 r_nstop_q;
  logic                 r_txd;

  logic w_bit_end;
  logic w_baud_en;
  logic w_last_stop;
  logic w_rd_en;

  assign w_baud_en   = (r_state == Start) | (r_state == Data) | (r_state == Stop);
  // Last cycle of the final stop bit: the only point besides Idle where the next byte may be popped.
  assign w_last_stop = (r_state == Stop) & w_bit_end & (r_stop_cnt == r_nstop_q);
  // Reset gating keeps the pop request low while the engine is held in reset.
  assign w_rd_en     = ~reset & txen & ~fifo_empty & ((r_state == Idle) | w_last_stop);

  assign fifo_rd_en = w_rd_en;
  assign txd        = r_txd;
  assign busy       = (r_state != Idle);

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (r_state == Fetch),
    .i_en      (w_baud_en),
    .i_div     (r_div_q),
    .o_bit_end (w_bit_end)
  );

  // Transmit FSM; txd is assigned on each transition so it shows the new state's level on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= Idle;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_div_q    <= {DIV_WIDTH{1'b0}};
      r_nstop_q  <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        Idle: begin
          r_txd <= 1'b1;
          if (w_rd_en) begin
            r_state <= Fetch;
          end else begin
            r_state <= Idle;
          end
        end
        Fetch: begin
          // Frame parameters are frozen here; later div/nstop changes wait for the next frame.
          r_shift    <= fifo_rd_data;
          r_div_q    <= div;
          r_nstop_q  <= nstop;
          r_bit_cnt  <= 3'd0;
          r_stop_cnt <= 1'b0;
          r_txd      <= 1'b0;
          r_state    <= Start;
        end
        Start: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_state <= Data;
          end else begin
            r_state <= Start;
          end
        end
        Data: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LastBit) begin
              r_txd      <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= Stop;
            end else begin
              // Present the next bit in the same edge that retires the current one.
              r_txd     <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_state   <= Data;
            end
          end else begin
            r_state <= Data;
          end
        end
        Stop: begin
          r_txd <= 1'b1;
          if (w_last_stop) begin
            if (w_rd_en) begin
              r_state <= Fetch;
            end else begin
              r_state <= Idle;
            end
          end else if (w_bit_end) begin
            r_stop_cnt <= 1'b1;
            r_state    <= Stop;
          end else begin
            r_state <= Stop;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_phy.sv
// tb_uart_tx_phy: self-checking bench for uart_tx_phy.
//   Expected txd/busy traces are built per frame from the line format (fetch cycle,
//   start bit, 8 data bits LSB first, stop bits), each bit lasting div+1 cycles.
module tb_uart_tx_phy;

  logic        clock = 1'b0;
  logic        reset;
  logic        txen;
  logic        nstop;
  logic [15:0] div;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        txd;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uart_tx_phy #(.DIV_WIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .txen         (txen),
    .nstop        (nstop),
    .div          (div),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .busy         (busy)
  );

  // FIFO model: registered read, empty flag refreshed every clock.
  logic [7:0] fq[$];
  int pop_count = 0;
  int bad_pop   = 0;

  always @(posedge clock) begin
    if (fifo_rd_en === 1'b1) begin
      if (fifo_empty !== 1'b0 || txen !== 1'b1 || fq.size() == 0) begin
        bad_pop++;
      end else begin
        fifo_rd_data <= fq.pop_front();
        pop_count++;
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Reference trace, one entry per clock starting with the fetch cycle.
  logic exp_txd[$];
  logic exp_busy[$];

  function automatic void add_frame(input logic [7:0] b, input int d, input int ns);
    exp_txd.push_back(1'b1); exp_busy.push_back(1'b1);
    repeat (d + 1) begin exp_txd.push_back(1'b0); exp_busy.push_back(1'b1); end
    for (int i = 0; i < 8; i++) begin
      repeat (d + 1) begin exp_txd.push_back(b[i]); exp_busy.push_back(1'b1); end
    end
    repeat ((1 + ns) * (d + 1)) begin exp_txd.push_back(1'b1); exp_busy.push_back(1'b1); end
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) begin exp_txd.push_back(1'b1); exp_busy.push_back(1'b0); end
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a pop request; samples the current cycle first.
  task automatic wait_pop(input string tag, output int waited);
    logic found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (fifo_rd_en === 1'b1) begin
        found = 1'b1;
        break;
      end
      waited++;
      @(negedge clock);
    end
    chk({tag, " pop_seen"}, found, 1'b1);
  endtask

  // Compares txd/busy cycle by cycle against the reference trace, optionally
  // dropping txen or changing div at given trace indices.
  task automatic run_stream(input string tag, input int exp_pops, input int txen_off_at,
                            input int div_at, input logic [15:0] new_div);
    int p0;
    p0 = pop_count;
    for (int k = 0; k < exp_txd.size(); k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("%s txd[%0d]", tag, k), txd, exp_txd[k]);
      chk($sformatf("%s busy[%0d]", tag, k), busy, exp_busy[k]);
      if (k == txen_off_at) txen = 1'b0;
      if (k == div_at) div = new_div;
    end
    chk_int({tag, " pops"}, pop_count - p0, exp_pops);
    exp_txd.delete();
    exp_busy.delete();
  endtask

  initial begin
    int w;
    logic [7:0] rb [3];
    int rd;
    int rns;

    // Reset held with a non-empty FIFO and txen=1.
    reset = 1'b1;
    txen  = 1'b1;
    nstop = 1'b0;
    div   = 16'd3;
    fq.push_back(8'hA5);
    repeat (3) @(negedge clock);
    #1;
    chk("rst txd", txd, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst rd_en", fifo_rd_en, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_pop("a5", w);
    chk_int("a5 first_clock_pop", w, 0);
    add_frame(8'hA5, 3, 0);
    add_idle(3);
    run_stream("a5", 1, -1, -1, 16'd0);

    // 0x0F, div=1, two stop bits.
    txen = 1'b0;
    fq.push_back(8'h0F);
    repeat (2) @(negedge clock);
    div   = 16'd1;
    nstop = 1'b1;
    txen  = 1'b1;
    wait_pop("0f", w);
    add_frame(8'h0F, 1, 1);
    add_idle(3);
    run_stream("0f", 1, -1, -1, 16'd0);

    // Two queued bytes, div=0: back-to-back frames.
    txen = 1'b0;
    fq.push_back(8'h55);
    fq.push_back(8'hAA);
    repeat (2) @(negedge clock);
    div   = 16'd0;
    nstop = 1'b0;
    txen  = 1'b1;
    wait_pop("b2b", w);
    add_frame(8'h55, 0, 0);
    add_frame(8'hAA, 0, 0);
    add_idle(3);
    run_stream("b2b", 2, -1, -1, 16'd0);

    // txen dropped during data bit 3 of 0x81 (div=2); 0x33 must stay queued.
    txen = 1'b0;
    fq.push_back(8'h81);
    fq.push_back(8'h33);
    repeat (2) @(negedge clock);
    div   = 16'd2;
    nstop = 1'b0;
    txen  = 1'b1;
    wait_pop("txoff", w);
    add_frame(8'h81, 2, 0);
    add_idle(6);
    run_stream("txoff", 1, 14, -1, 16'd0);
    chk_int("txoff fifo_left", fq.size(), 1);

    // div 3 -> 7 during data of the first frame; second frame uses the new divisor.
    rb[0] = 8'($urandom);
    rns   = int'($urandom_range(0, 1));
    fq.push_back(rb[0]);
    repeat (2) @(negedge clock);
    div   = 16'd3;
    nstop = rns[0];
    txen  = 1'b1;
    wait_pop("divchg", w);
    add_frame(8'h33, 3, rns);
    add_frame(rb[0], 7, rns);
    add_idle(3);
    run_stream("divchg", 2, -1, 10, 16'd7);

    // Randomized back-to-back frames.
    txen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rb[i] = 8'($urandom);
      fq.push_back(rb[i]);
    end
    rd  = int'($urandom_range(0, 3));
    rns = int'($urandom_range(0, 1));
    repeat (2) @(negedge clock);
    div   = 16'(rd);
    nstop = rns[0];
    txen  = 1'b1;
    wait_pop("rand", w);
    for (int i = 0; i < 3; i++) add_frame(rb[i], rd, rns);
    add_idle(3);
    run_stream("rand", 3, -1, -1, 16'd0);

    // Asynchronous reset in the middle of the data bits.
    txen = 1'b0;
    fq.push_back(8'hC3);
    repeat (2) @(negedge clock);
    div   = 16'd2;
    nstop = 1'b0;
    txen  = 1'b1;
    wait_pop("midrst", w);
    repeat (8) @(negedge clock);
    #1;
    chk("midrst busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst txd", txd, 1'b1);
    chk("midrst busy", busy, 1'b0);
    chk("midrst rd_en", fifo_rd_en, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    w = pop_count;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("postrst txd[%0d]", k), txd, 1'b1);
      chk($sformatf("postrst busy[%0d]", k), busy, 1'b0);
    end
    chk_int("postrst pops", pop_count - w, 0);

    chk_int("illegal_pops", bad_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
